// File: rtl/control_refresco_datos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rtc_pkg
//  Description : Shared constants, byte map and state encoding for the
//                RTC-to-display refresh controller.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_rtc_pkg;

    localparam int N_REG    = 11;
    localparam int ADDR_W   = 4;
    localparam int V_ACTIVE = 480;
    localparam int TIMEOUT  = 15;

    // Byte positions inside the display bank
    localparam int SEG    = 0;
    localparam int MIN    = 1;
    localparam int HORA   = 2;
    localparam int FECHA  = 3;
    localparam int MES    = 4;
    localparam int ANO    = 5;
    localparam int DIASEM = 6;
    localparam int NUMSEM = 7;
    localparam int SEGT   = 8;
    localparam int MINT   = 9;
    localparam int HORAT  = 10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_REQ    = 3'd1;
    localparam state_t ST_NEXT   = 3'd2;
    localparam state_t ST_COMMIT = 3'd3;
    localparam state_t ST_ABORT  = 3'd4;

    function automatic logic bcd_invalid(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_refresco_datos_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_refresco_datos_if
//  Description : RTC read port between the refresh controller and the RTC
//                bus controller, including the write-path busy flag.
//  Revision    : 1.0  initial release
// ============================================================================
interface control_refresco_datos_if #(
    parameter int ADDR_W = vga_rtc_pkg::ADDR_W
) ();

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [7:0]        rd_data;
    logic              bus_busy;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data,
        input  bus_busy
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data,
        output bus_busy
    );

endinterface
`default_nettype wire

// File: rtl/control_refresco_datos_detector_vblank.sv
`default_nettype none
// ============================================================================
//  Module      : detector_vblank
//  Description : Detects the first row of vertical blanking against a
//                registered copy of pixely and reports the blanking window.
//  Revision    : 1.0  initial release
// ============================================================================
module detector_vblank #(
    parameter int V_ACTIVE = vga_rtc_pkg::V_ACTIVE
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [9:0] i_pixely,
    output logic            o_vb_start,
    output logic            o_window
);

    localparam logic [9:0] C_V_ACTIVE = 10'(V_ACTIVE);

    logic [9:0] r_pixely_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixely_prev <= '0;
        end else begin
            r_pixely_prev <= i_pixely;
        end
    end

    assign o_window   = (i_pixely >= C_V_ACTIVE);
    assign o_vb_start = (r_pixely_prev < C_V_ACTIVE) && o_window;

endmodule
`default_nettype wire

// File: rtl/control_refresco_datos.sv
`default_nettype none
// ============================================================================
//  Module      : control_refresco_datos
//  Description : Captures the RTC time/timer bytes into a shadow bank during
//                vertical blanking and commits them atomically to the display.
//  Revision    : 1.0  initial release
// ============================================================================
module control_refresco_datos #(
    parameter int N_REG    = vga_rtc_pkg::N_REG,
    parameter int ADDR_W   = vga_rtc_pkg::ADDR_W,
    parameter int V_ACTIVE = vga_rtc_pkg::V_ACTIVE,
    parameter int TIMEOUT  = vga_rtc_pkg::TIMEOUT
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [9:0]            pixely,
    input  wire logic                  forzar,
    control_refresco_datos_if.master   rd_bus,
    output logic [8*N_REG-1:0]         datos_o,
    output logic                       commit,
    output logic                       bcd_err,
    output logic                       timeout_err,
    output logic                       busy
);

    import vga_rtc_pkg::*;

    localparam int                C_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_TO_CNT = C_CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(N_REG - 1);

    state_t               r_state;
    logic [ADDR_W-1:0]    r_idx;
    logic [C_CNT_W-1:0]   r_wait;
    logic                 r_forced;
    logic                 r_bcd_flag;
    logic [8*N_REG-1:0]   r_shadow;
    logic [8*N_REG-1:0]   r_datos;
    logic                 r_commit;
    logic                 r_bcd_err;
    logic                 r_timeout_err;

    logic                 w_vb_start;
    logic                 w_window;
    logic                 w_req;
    logic                 w_hit;
    logic [C_CNT_W-1:0]   w_wait_next;
    logic                 w_timeout;

    detector_vblank #(
        .V_ACTIVE (V_ACTIVE)
    ) u_detector_vblank (
        .clk        (clk),
        .rst        (reset),
        .i_pixely   (pixely),
        .o_vb_start (w_vb_start),
        .o_window   (w_window)
    );

    // The request drops in the same cycle the write path claims the bus.
    assign w_req       = (r_state == ST_REQ) && !rd_bus.bus_busy;
    assign w_hit       = w_req && rd_bus.rd_ack;
    assign w_wait_next = (w_req && (r_wait != C_TO_CNT)) ? r_wait + 1'b1 : r_wait;
    assign w_timeout   = w_req && (w_wait_next == C_TO_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_wait        <= '0;
            r_forced      <= 1'b0;
            r_bcd_flag    <= 1'b0;
            r_shadow      <= '0;
            r_datos       <= '0;
            r_commit      <= 1'b0;
            r_bcd_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_vb_start || forzar) begin
                        r_state    <= ST_REQ;
                        r_idx      <= '0;
                        r_wait     <= '0;
                        r_forced   <= forzar;
                        r_bcd_flag <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // An accepted ack wins over a closing window or timeout.
                    if (w_hit) begin
                        for (int k = 0; k < N_REG; k++) begin
                            if (r_idx == ADDR_W'(k)) begin
                                r_shadow[8*k +: 8] <= rd_bus.rd_data;
                            end
                        end
                        if (bcd_invalid(rd_bus.rd_data)) begin
                            r_bcd_flag <= 1'b1;
                        end
                        r_state <= ST_NEXT;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_ABORT;
                    end else if (!r_forced && !w_window) begin
                        r_state <= ST_ABORT;
                    end else begin
                        r_wait <= w_wait_next;
                    end
                end
                ST_NEXT: begin
                    r_wait <= '0;
                    if (r_idx == C_LAST) begin
                        r_datos       <= r_shadow;
                        r_commit      <= 1'b1;
                        r_bcd_err     <= r_bcd_flag;
                        r_timeout_err <= 1'b0;
                        r_state       <= ST_COMMIT;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                end
                ST_ABORT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_bus.rd_req  = w_req;
    assign rd_bus.rd_addr = r_idx;
    assign datos_o        = r_datos;
    assign commit         = r_commit;
    assign bcd_err        = r_bcd_err;
    assign timeout_err    = r_timeout_err;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_control_refresco_datos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_refresco_datos
//  Description : Randomized bench for the display refresh controller with a
//                capture-level outcome model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_refresco_datos;

    localparam int N_REG   = 11;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               forzar;
    logic [9:0]         pixely;
    logic [8*N_REG-1:0] datos_o;
    logic               commit;
    logic               bcd_err;
    logic               timeout_err;
    logic               busy;

    control_refresco_datos_if #(.ADDR_W(ADDR_W)) bus ();

    control_refresco_datos dut (
        .clk         (clk),
        .reset       (reset),
        .pixely      (pixely),
        .forzar      (forzar),
        .rd_bus      (bus),
        .datos_o     (datos_o),
        .commit      (commit),
        .bcd_err     (bcd_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected display state
    logic [7:0] m_bank [N_REG];
    bit         m_bcd;
    bit         m_to;

    // Per-capture responder script
    logic [7:0] s_data [N_REG];
    int         s_dly  [N_REG];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8*N_REG-1:0] pack_model();
        logic [8*N_REG-1:0] r;
        for (int j = 0; j < N_REG; j++) r[8*j +: 8] = m_bank[j];
        return r;
    endfunction

    function automatic bit is_bad(input logic [7:0] b);
        return (int'(b) / 16 > 9) || (int'(b) % 16 > 9);
    endfunction

    task automatic clear_model();
        for (int j = 0; j < N_REG; j++) m_bank[j] = 8'h00;
        m_bcd = 0;
        m_to  = 0;
    endtask

    task automatic run_capture(input bit forced, input bit vb, input bit use_busy,
                               input int stuck_at, input int close_at, input int bad_at,
                               input bit fixed, input bit poke, input int reset_at);
        int k = 0, hi = 0, n_com = 0, com_cyc = -1, exp_lat = 1;
        bit seen_busy = 0, done = 0, close_now = 0, rst_hit = 0, exp_commit, any_bad = 0;

        for (int j = 0; j < N_REG; j++) begin
            if (fixed) begin
                s_data[j] = 8'h10 + 8'(j);
                s_dly[j]  = 1;
            end else begin
                s_data[j] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                s_dly[j]  = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 14) : $urandom_range(0, 3);
            end
        end
        if (bad_at >= 0)
            s_data[bad_at] = fixed ? 8'h3A : {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
        if (close_at >= 0) s_dly[close_at] = forced ? 2 : 14;
        for (int j = 0; j < N_REG; j++) begin
            exp_lat += s_dly[j] + 2;
            if (is_bad(s_data[j])) any_bad = 1;
        end

        if (vb) begin
            pixely = 10'd479;
            tick();
        end

        for (int it = 0; it < 600; it++) begin
            if (rst_hit) begin
                chk("rst_busy", busy, 0);
                chk("rst_req", bus.rd_req, 0);
                chk("rst_addr", bus.rd_addr, 0);
                chk("rst_datos", datos_o, 0);
                chk("rst_flags", {commit, bcd_err, timeout_err}, 0);
                reset = 1'b0;
                clear_model();
                done = 1;
                break;
            end
            if (commit) begin
                n_com++;
                com_cyc = it;
            end
            if (busy) seen_busy = 1;
            else if (seen_busy) begin
                done = 1;
                break;
            end

            forzar = (it == 0 && forced) || (poke && it == 20);
            if (it == 0)                pixely = vb ? 10'd480 : 10'd100;
            else if (close_now)         pixely = 10'd0;
            else if (poke && it == 20)  pixely = 10'd479;
            else if (vb)                pixely = (close_at >= 0) ? 10'd524 : 10'd500;
            bus.bus_busy = use_busy && ($urandom_range(0, 2) == 0);
            bus.rd_ack   = 1'($urandom_range(0, 1));
            bus.rd_data  = 8'($urandom);
            #1;
            if (bus.bus_busy) chk("req_gated", bus.rd_req, 0);
            if (bus.rd_req) begin
                chk("rd_addr", bus.rd_addr, k);
                bus.rd_ack = 1'b0;
                if (k == reset_at) begin
                    reset   = 1'b1;
                    rst_hit = 1;
                end else if (k < N_REG) begin
                    if (k == close_at) close_now = 1;
                    if (k != stuck_at && hi == s_dly[k]) begin
                        bus.rd_ack  = 1'b1;
                        bus.rd_data = s_data[k];
                        k++;
                        hi = 0;
                    end else begin
                        hi++;
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        chk("capture_end", done, 1);
        forzar       = 1'b0;
        bus.rd_ack   = 1'b0;
        bus.bus_busy = 1'b0;
        if (rst_hit) begin
            pixely = 10'd100;
            repeat (2) tick();
            return;
        end
        repeat (3) begin
            tick();
            chk("idle_hold", {busy, commit}, 0);
        end

        exp_commit = (stuck_at < 0) && !(close_at >= 0 && !forced);
        chk("n_commit", n_com, exp_commit);
        if (stuck_at >= 0) begin
            chk("to_req_cycles", hi, TIMEOUT);
            chk("to_addr", k, stuck_at);
            m_to = 1;
        end
        if (exp_commit) begin
            if (!use_busy) chk("latency", com_cyc, exp_lat);
            for (int j = 0; j < N_REG; j++) m_bank[j] = s_data[j];
            m_bcd = any_bad;
            m_to  = 0;
        end
        chk("datos", datos_o, pack_model());
        chk("bcd_err", bcd_err, m_bcd);
        chk("timeout_err", timeout_err, m_to);

        pixely = 10'd100;
        repeat (2) tick();
    endtask

    initial begin
        reset        = 1'b1;
        forzar       = 1'b0;
        pixely       = 10'd100;
        bus.bus_busy = 1'b0;
        bus.rd_ack   = 1'b0;
        bus.rd_data  = 8'h00;
        clear_model();
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_req", bus.rd_req, 0);
        chk("reset_addr", bus.rd_addr, 0);
        chk("reset_datos", datos_o, 0);
        chk("reset_flags", {commit, bcd_err, timeout_err}, 0);
        reset = 1'b0;
        repeat (2) tick();

        // forced, vb, busy, stuck, close, bad, fixed, poke, reset_at
        run_capture(0, 1, 0, -1, -1, -1, 1, 0, -1);
        chk("byte0", datos_o[7:0], 8'h10);
        chk("byte10", datos_o[87:80], 8'h1A);
        run_capture(0, 1, 0,  0, -1, -1, 0, 0, -1);
        run_capture(0, 1, 0, -1, -1, -1, 0, 0, -1);
        run_capture(0, 1, 1, -1, -1, -1, 0, 0, -1);
        run_capture(0, 1, 0, -1,  6, -1, 0, 0, -1);
        run_capture(1, 0, 0, -1,  6, -1, 0, 0, -1);
        run_capture(0, 1, 0, -1, -1,  2, 1, 0, -1);
        chk("byte2_bad", datos_o[23:16], 8'h3A);
        run_capture(0, 1, 0, -1, -1, -1, 0, 0, -1);
        run_capture(1, 1, 0, -1, -1, -1, 1, 1, -1);

        for (int r = 0; r < 14; r++) begin
            int sel;
            bit f;
            sel = $urandom_range(0, 4);
            f   = ($urandom_range(0, 3) == 0);
            run_capture(f, !f || ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)),
                        (sel == 0) ? $urandom_range(0, N_REG - 1) : -1,
                        (sel == 1) ? $urandom_range(0, N_REG - 1) : -1,
                        (sel == 2) ? $urandom_range(0, N_REG - 1) : -1,
                        0, 0, -1);
        end

        run_capture(1, 0, 0, -1, -1, -1, 0, 0, 5);
        run_capture(0, 1, 0, -1, -1, -1, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
